// File: rtl/ltc2308_pkg.sv
// Shared types and helpers for the LTC2308 scan sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ltc2308_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONV_HI   = 3'd1,
        S_CONV_WAIT = 3'd2,
        S_SHIFT     = 3'd3,
        S_EMIT      = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    localparam int N_BITS   = 12;
    localparam int CFG_BITS = 6;

    // Single-ended, no sleep: {S/D, O/S, S1, S0, UNI, SLP}, shifted MSB first.
    function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch, input logic uni);
        return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
    endfunction

endpackage

// File: rtl/ltc2308_rr_pick.sv
// Round-robin channel picker: first set mask bit above 'last', wrapping 7->0.
// Latency: combinational.
// Backpressure: none; 'any' is low when the mask is empty.
module ltc2308_rr_pick (
    input  logic [7:0] mask,
    input  logic [2:0] last,
    output logic [2:0] next,
    output logic       any
);

    logic [2:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins; offset 8 is 'last' itself.
    always_comb begin
        next = last;
        cand = last;
        any  = |mask;
        for (int i = 8; i >= 1; i--) begin
            cand = last + 3'(i);
            if (mask[cand]) begin
                next = cand;
            end
        end
    end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// LTC2308 scan sequencer: CONVST/SCK/SDI generation, SDO capture, tagged results.
// Latency: one result per frame of CONVST_HI+T_CONV+24*CLK_DIV+1+GAP clk, one frame behind its config.
// Backpressure: none; result_valid is a single-cycle strobe the consumer must take.
module ltc2308_scan_ctrl
    import ltc2308_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int CONVST_HI = 2,
    parameter int T_CONV    = 80,
    parameter int GAP       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [7:0]        ch_mask,
    input  logic              uni,
    output logic              result_valid,
    output logic [2:0]        result_ch,
    output logic [N_BITS-1:0] result_data,
    output logic              busy,
    output logic              adc_convst,
    output logic              adc_sck,
    output logic              adc_sdi,
    input  logic              adc_sdo
);

    localparam int CNT_A   = (CONVST_HI > T_CONV) ? CONVST_HI : T_CONV;
    localparam int CNT_B   = (GAP > CLK_DIV) ? GAP : CLK_DIV;
    localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_CHI  = CW'(CONVST_HI - 1);
    localparam logic [CW-1:0] LD_WAIT = CW'(T_CONV - 1);
    localparam logic [CW-1:0] LD_HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LD_GAP  = CW'(GAP - 1);
    localparam logic [3:0]    LAST_BIT = 4'(N_BITS - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              phase;      // 0 = SCK low half, 1 = SCK high half
    logic [3:0]        bit_idx;
    logic [N_BITS-1:0] shreg;
    logic              prime;
    logic [2:0]        last_ch, prev_ch, cfg_ch;
    logic              cfg_uni;
    logic [2:0]        pick_ch;
    logic              pick_any;
    logic [N_BITS-1:0] sdi_word;
    logic [3:0]        sdi_idx;
    logic              convst_d, sck_d, sdi_d, busy_d, emit_d;

    ltc2308_rr_pick u_pick (
        .mask (ch_mask),
        .last (last_ch),
        .next (pick_ch),
        .any  (pick_any)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; a started frame always runs through to GAP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (enable && pick_any) state_nxt = S_CONV_HI;
            S_CONV_HI:   if (cnt == '0) state_nxt = S_CONV_WAIT;
            S_CONV_WAIT: if (cnt == '0) state_nxt = S_SHIFT;
            S_SHIFT:     if (cnt == '0 && phase && bit_idx == LAST_BIT) state_nxt = S_EMIT;
            S_EMIT:      state_nxt = S_GAP;
            S_GAP:       if (cnt == '0) state_nxt = (enable && pick_any) ? S_CONV_HI : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Shared counter, SCK phase/bit index, SDO capture and per-frame channel bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
            prime   <= 1'b1;
            last_ch <= 3'd7;
            prev_ch <= 3'd0;
            cfg_ch  <= 3'd0;
            cfg_uni <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                case (state_nxt)
                    S_CONV_HI: begin
                        cnt     <= LD_CHI;
                        cfg_ch  <= pick_ch;
                        cfg_uni <= uni;
                        if (state == S_IDLE) prime <= 1'b1;
                    end
                    S_CONV_WAIT: cnt <= LD_WAIT;
                    S_SHIFT: begin
                        cnt     <= LD_HALF;
                        phase   <= 1'b0;
                        bit_idx <= '0;
                    end
                    S_GAP:   cnt <= LD_GAP;
                    default: cnt <= '0;
                endcase
            end else if (state == S_SHIFT) begin
                if (cnt == '0) begin
                    cnt   <= LD_HALF;
                    phase <= ~phase;
                    if (phase) bit_idx <= bit_idx + 4'd1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // The SCK pin lags the internal phase by one clk, so the first internal high
            // cycle is the last pin-low cycle: capture SDO just before the rising edge.
            if (state == S_SHIFT && phase && cnt == LD_HALF) begin
                shreg <= {shreg[N_BITS-2:0], adc_sdo};
            end
            if (state == S_EMIT) begin
                prime   <= 1'b0;
                prev_ch <= cfg_ch;
                last_ch <= cfg_ch;
            end
        end
    end

    assign sdi_word = {cfg_word(cfg_ch, cfg_uni), {(N_BITS - CFG_BITS){1'b0}}};
    assign sdi_idx  = LAST_BIT - bit_idx;

    // Output decode from the current state; SDI holds for the whole bit period.
    always_comb begin
        convst_d = (state == S_CONV_HI);
        sck_d    = (state == S_SHIFT) && phase;
        sdi_d    = (state == S_SHIFT) && sdi_word[sdi_idx];
        busy_d   = (state != S_IDLE);
        emit_d   = (state == S_EMIT) && !prime;
    end

    // Registered pins and result; the pipelined ADC returns the previous frame's channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            result_ch    <= 3'd0;
            result_data  <= '0;
            busy         <= 1'b0;
            adc_convst   <= 1'b0;
            adc_sck      <= 1'b0;
            adc_sdi      <= 1'b0;
        end else begin
            result_valid <= emit_d;
            busy         <= busy_d;
            adc_convst   <= convst_d;
            adc_sck      <= sck_d;
            adc_sdi      <= sdi_d;
            if (emit_d) begin
                result_ch   <= prev_ch;
                result_data <= shreg;
            end
        end
    end

endmodule
